sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter_pkg.sv | 25 ++
 rtl/sram_arbiter_if.sv | 21 ++
 rtl/sram_arbiter_rr_arbiter.sv | 37 +++
 rtl/sram_arbiter.sv | 152 +++++++++++++++
 tb/tb_sram_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types, defaults and helpers for the SRAM arbiter.
// Optional build macro SRAM_ARB_PRIORITY_EN is consumed by rr_arbiter.
package sram_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

   localparam int unsigned DEF_NUM_CH    = 3;
   localparam int unsigned DEF_ADDR_W    = 19;
   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_RD_CYCLES = 2;
   localparam int unsigned DEF_WR_CYCLES = 3;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = 1;
      while (x < v) begin
         x = x << 1;
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: flattened per-channel request/ack
// handshake plus the shared read-data return.
interface sram_arbiter_if
   import sram_arb_pkg::*;
#(
   parameter int unsigned NUM_CH = DEF_NUM_CH,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) ();

   logic [NUM_CH-1:0]        req;
   logic [NUM_CH-1:0]        we;
   logic [NUM_CH*ADDR_W-1:0] addr;
   logic [NUM_CH*DATA_W-1:0] wdata;
   logic [NUM_CH-1:0]        ack;
   logic [DATA_W-1:0]        rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/sram_arbiter_rr_arbiter.sv
// Combinational round-robin grant, search starting after the last grant.
// With SRAM_ARB_PRIORITY_EN defined, ch0 overrides the round-robin.
module rr_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned NUM_CH = DEF_NUM_CH,
   parameter int unsigned IDX_W  = 2
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  last,
   output logic [NUM_CH-1:0] gnt
);

   always_comb begin
      int unsigned idx;
      logic        found;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
`ifdef SRAM_ARB_PRIORITY_EN
      // When ch0 is idle the rotating search skips it naturally.
      if (req[0]) begin
         gnt[0] = 1'b1;
         found  = 1'b1;
      end
`endif
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         idx = 32'(last) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!found && req[IDX_W'(idx)]) begin
            gnt[IDX_W'(idx)] = 1'b1;
            found            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// N-channel arbiter and strobe timing controller for the 512Kx8 async SRAM.
// Build option: SRAM_ARB_PRIORITY_EN gives ch0 fixed priority.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned NUM_CH    = DEF_NUM_CH,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned RD_CYCLES = DEF_RD_CYCLES,
   parameter int unsigned WR_CYCLES = DEF_WR_CYCLES
) (
   input  logic              clk50,
   input  logic              rst,
   sram_arbiter_if.slave     bus,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data_out,
   output logic              ram_data_oe,
   input  logic [DATA_W-1:0] ram_data_in,
   output logic              ram_cel,
   output logic              ram_oel,
   output logic              ram_wel
);

   localparam int unsigned IDX_W   = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
   localparam int unsigned MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
   localparam int unsigned CNT_W   = clog2(MAX_CYC) + 1;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    ch_q, ch_d;
   logic                we_q, we_d;
   logic [NUM_CH-1:0]   ack_q, ack_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   dout_d;
   logic                oe_d, cel_d, oel_d, wel_d;

   logic [NUM_CH-1:0]   gnt;
   logic [IDX_W-1:0]    g_idx;
   logic                g_we;
   logic [ADDR_W-1:0]   g_addr;
   logic [DATA_W-1:0]   g_wdata;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_rr (
      .req  (bus.req),
      .last (ch_q),
      .gnt  (gnt)
   );

   always_comb begin
      g_idx   = '0;
      g_we    = 1'b0;
      g_addr  = '0;
      g_wdata = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (gnt[c]) begin
            g_idx   = IDX_W'(c);
            g_we    = bus.we[c];
            g_addr  = bus.addr[c*ADDR_W +: ADDR_W];
            g_wdata = bus.wdata[c*DATA_W +: DATA_W];
         end
      end
   end

   // Pin values are computed one edge ahead so every strobe leaves a flop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ch_d    = ch_q;
      we_d    = we_q;
      addr_d  = ram_addr;
      dout_d  = ram_data_out;
      oe_d    = ram_data_oe;
      cel_d   = ram_cel;
      oel_d   = 1'b1;
      wel_d   = 1'b1;
      ack_d   = '0;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d = ACCESS;
               ch_d    = g_idx;
               we_d    = g_we;
               addr_d  = g_addr;
               dout_d  = g_wdata;
               cnt_d   = g_we ? CNT_W'(WR_CYCLES - 1) : CNT_W'(RD_CYCLES - 1);
               cel_d   = 1'b0;
               oel_d   = g_we;
               wel_d   = !g_we;
               oe_d    = g_we;
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d     = RECOVER;
               ack_d[ch_q] = 1'b1;
               if (!we_q) rdata_d = ram_data_in;
            end else begin
               cnt_d = cnt_q - 1'b1;
               oel_d = we_q;
               wel_d = !we_q;
            end
         end
         RECOVER: begin
            state_d = IDLE;
            cel_d   = 1'b1;
            oe_d    = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk50) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         ch_q         <= IDX_W'(NUM_CH - 1);
         we_q         <= 1'b0;
         ack_q        <= '0;
         rdata_q      <= '0;
         ram_addr     <= '0;
         ram_data_out <= '0;
         ram_data_oe  <= 1'b0;
         ram_cel      <= 1'b1;
         ram_oel      <= 1'b1;
         ram_wel      <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ch_q         <= ch_d;
         we_q         <= we_d;
         ack_q        <= ack_d;
         rdata_q      <= rdata_d;
         ram_addr     <= addr_d;
         ram_data_out <= dout_d;
         ram_data_oe  <= oe_d;
         ram_cel      <= cel_d;
         ram_oel      <= oel_d;
         ram_wel      <= wel_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign bus.ack   = ack_q;
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: vector table of single accesses plus
// hand-written contention, reset-mid-write and dropped-request sequences.
module tb_sram_arbiter;
   import sram_arb_pkg::*;

   localparam int unsigned NUM_CH    = 3;
   localparam int unsigned ADDR_W    = 19;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned RD_CYCLES = 2;
   localparam int unsigned WR_CYCLES = 3;

   logic              clk50 = 1'b0;
   logic              rst;
   logic              busy;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data_out;
   logic              ram_data_oe;
   logic [DATA_W-1:0] ram_data_in;
   logic              ram_cel, ram_oel, ram_wel;

   always #5 clk50 = ~clk50;

   sram_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sram_arbiter #(
      .NUM_CH    (NUM_CH),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .RD_CYCLES (RD_CYCLES),
      .WR_CYCLES (WR_CYCLES)
   ) dut (
      .clk50        (clk50),
      .rst          (rst),
      .bus          (bus),
      .busy         (busy),
      .ram_addr     (ram_addr),
      .ram_data_out (ram_data_out),
      .ram_data_oe  (ram_data_oe),
      .ram_data_in  (ram_data_in),
      .ram_cel      (ram_cel),
      .ram_oel      (ram_oel),
      .ram_wel      (ram_wel)
   );

   logic [7:0] mem [0:(1<<19)-1];
   assign ram_data_in = mem[ram_addr];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // SRAM model: a write lands on the rising edge of ram_wel.
   logic              wr_seen;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   always @(posedge ram_wel) begin
      if (!ram_cel && ram_data_oe) begin
         wr_seen       = 1'b1;
         wr_addr       = ram_addr;
         wr_data       = ram_data_out;
         mem[ram_addr] = ram_data_out;
      end
   end

   logic              prev_strobe = 1'b0;
   logic [ADDR_W-1:0] prev_addr   = '0;
   always @(negedge clk50) begin
      if (prev_strobe && (!ram_oel || !ram_wel))
         check("addr_stable", 32'(ram_addr), 32'(prev_addr));
      prev_strobe = !ram_oel || !ram_wel;
      prev_addr   = ram_addr;
   end

   task automatic drive(input int ch, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
      bus.we[ch]                    = w;
      bus.addr[ch*ADDR_W +: ADDR_W] = a;
      bus.wdata[ch*DATA_W +: DATA_W] = d;
      bus.req[ch]                   = 1'b1;
   endtask

   task automatic wait_ack(input int budget, output logic [NUM_CH-1:0] a, output int n,
                           output int oc, output int wc);
      a  = '0;
      n  = 0;
      oc = 0;
      wc = 0;
      while (n < budget) begin
         @(negedge clk50);
         n++;
         if (!ram_oel) oc++;
         if (!ram_wel) wc++;
         if (bus.ack != '0) begin
            a = bus.ack;
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk50);
      rst = 1'b1;
      @(negedge clk50);
      rst = 1'b0;
   endtask

   typedef struct {
      int                ch;
      logic              w;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic [DATA_W-1:0] exp_rd;
      int                exp_lat;
   } vec_t;

   vec_t vecs [7];
   int   exp_order [10];
   logic [7:0] ch_data [3];

   initial begin
      logic [NUM_CH-1:0] a;
      logic [NUM_CH-1:0] ack_seen;
      int n, oc, wc;

      bus.req   = '0;
      bus.we    = '0;
      bus.addr  = '0;
      bus.wdata = '0;
      wr_seen   = 1'b0;
      mem[19'h01234] = 8'hA5;
      mem[19'h00200] = 8'h42;
      mem[19'h00300] = 8'h99;

      //           ch  w     addr        wdata  exp_rd  lat
      vecs[0] = '{ 1, 1'b0, 19'h01234, 8'h00, 8'hA5, 3 };
      vecs[1] = '{ 2, 1'b1, 19'h7FFFF, 8'h3C, 8'h00, 4 };
      vecs[2] = '{ 0, 1'b0, 19'h7FFFF, 8'h00, 8'h3C, 3 };
      vecs[3] = '{ 0, 1'b1, 19'h00000, 8'hFF, 8'h00, 4 };
      vecs[4] = '{ 2, 1'b0, 19'h00000, 8'h00, 8'hFF, 3 };
      vecs[5] = '{ 1, 1'b1, 19'h55555, 8'h81, 8'h00, 4 };
      vecs[6] = '{ 1, 1'b0, 19'h55555, 8'h00, 8'h81, 3 };

`ifdef SRAM_ARB_PRIORITY_EN
      exp_order = '{0, 0, 0, 0, 0, 0, 1, 2, 1, 2};
`else
      exp_order = '{0, 1, 2, 0, 1, 2, 1, 2, 1, 2};
`endif

      rst = 1'b1;
      repeat (3) @(posedge clk50);
      @(negedge clk50);
      check("rst_ctrl", 32'({ram_cel, ram_oel, ram_wel, ram_data_oe, bus.ack, busy}),
            32'(8'b1110_0000));
      check("rst_addr",  32'(ram_addr), 32'h0);
      check("rst_dout",  32'(ram_data_out), 32'h0);
      check("rst_rdata", 32'(bus.rdata), 32'h0);
      rst = 1'b0;

      // Single accesses from the vector table
      for (int i = 0; i < 7; i++) begin
         @(negedge clk50);
         wr_seen = 1'b0;
         drive(vecs[i].ch, vecs[i].w, vecs[i].a, vecs[i].d);
         wait_ack(12, a, n, oc, wc);
         bus.req = '0;
         check($sformatf("v%0d_ack", i), 32'(a), 32'(1 << vecs[i].ch));
         check($sformatf("v%0d_lat", i), 32'(n), 32'(vecs[i].exp_lat));
         if (vecs[i].w) begin
            check($sformatf("v%0d_wel_cycles", i), 32'(wc), 32'(WR_CYCLES));
            check($sformatf("v%0d_oel_cycles", i), 32'(oc), 32'h0);
            check($sformatf("v%0d_wr_seen", i), 32'(wr_seen), 32'h1);
            check($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].a));
            check($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].d));
         end else begin
            check($sformatf("v%0d_oel_cycles", i), 32'(oc), 32'(RD_CYCLES));
            check($sformatf("v%0d_rdata", i), 32'(bus.rdata), 32'(vecs[i].exp_rd));
         end
         @(negedge clk50);
         check($sformatf("v%0d_idle", i), 32'({busy, ram_cel}), 32'(2'b01));
      end

      // Contention: all three read continuously; ch0 drops after six grants
      do_reset();
      ch_data = '{8'hA5, 8'h3C, 8'hFF};
      drive(0, 1'b0, 19'h01234, 8'h00);
      drive(1, 1'b0, 19'h7FFFF, 8'h00);
      drive(2, 1'b0, 19'h00000, 8'h00);
      for (int k = 0; k < 10; k++) begin
         wait_ack(12, a, n, oc, wc);
         check($sformatf("rr%0d_grant", k), 32'(a), 32'(1 << exp_order[k]));
         check($sformatf("rr%0d_interval", k), 32'(n), (k == 0) ? 32'(RD_CYCLES + 1)
                                                               : 32'(RD_CYCLES + 2));
         check($sformatf("rr%0d_rdata", k), 32'(bus.rdata), 32'(ch_data[exp_order[k]]));
         if (k == 5) bus.req[0] = 1'b0;
      end
      bus.req = '0;
      repeat (3) @(negedge clk50);

      // Reset asserted in the second ACCESS cycle of a write
      @(negedge clk50);
      drive(2, 1'b1, 19'h00100, 8'h77);
      repeat (2) @(negedge clk50);
      check("rstw_wel_low", 32'({ram_wel, ram_cel, busy}), 32'(3'b001));
      rst = 1'b1;
      @(negedge clk50);
      check("rstw_after", 32'({ram_wel, ram_cel, busy, bus.ack}), 32'(6'b110000));
      rst     = 1'b0;
      bus.req = '0;
      ack_seen = '0;
      repeat (8) begin
         @(negedge clk50);
         ack_seen = ack_seen | bus.ack;
      end
      check("rstw_no_ack", 32'(ack_seen), 32'h0);

      // Dropped request with inputs changed after grant; ch2 waits behind it
      do_reset();
      drive(1, 1'b0, 19'h00200, 8'h00);
      drive(2, 1'b0, 19'h00300, 8'h00);
      @(negedge clk50);
      bus.req[1]                   = 1'b0;
      bus.we[1]                    = 1'b1;
      bus.addr[1*ADDR_W +: ADDR_W] = 19'h00300;
      wait_ack(12, a, n, oc, wc);
      check("drop_ack", 32'(a), 32'(3'b010));
      check("drop_lat", 32'(n), 32'h2);
      check("drop_wel", 32'(wc), 32'h0);
      check("drop_rdata", 32'(bus.rdata), 32'h42);
      wait_ack(12, a, n, oc, wc);
      check("drop_next_ack", 32'(a), 32'(3'b100));
      check("drop_next_lat", 32'(n), 32'(RD_CYCLES + 2));
      check("drop_next_rdata", 32'(bus.rdata), 32'h99);
      bus.req = '0;
      repeat (3) @(negedge clk50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
